// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register map,
// STATUS bit positions and byte-lane helpers.
package dmem_pkg;

  localparam logic [1:0] OFF_LED    = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int ST_MATCH = 0;
  localparam int ST_ERR   = 1;

  // Only byte, aligned halfword and full-word strobes are accepted.
  function automatic logic legalWen(input logic [3:0] wen);
    case (wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  // Replace only the enabled byte lanes of oldVal with newVal.
  function automatic logic [31:0] laneMerge(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  wen);
    logic [31:0] r;
    r = oldVal;
    for (int i = 0; i < 4; i++)
      if (wen[i]) r[8*i +: 8] = newVal[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port byte-writable synchronous RAM, one 8-bit bank per lane.
// The read register only moves on a read, so it holds between reads.
module dmem_ram #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              re,
  input  logic              we,
  input  logic [3:0]        wen,
  input  logic [RAM_AW-1:0] idx,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  for (genvar g = 0; g < 4; g++) begin : gLane
    logic [7:0] mem [1<<RAM_AW];
    logic [7:0] laneQ;

    // Lane write plus write-first read register.
    always_ff @(posedge clk) begin
      if (we && wen[g]) mem[idx] <= wdata[8*g +: 8];
      if (re) laneQ <= (we && wen[g]) ? wdata[8*g +: 8] : mem[idx];
    end

    assign q[8*g +: 8] = laneQ;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: decodes RAM vs MMIO, owns the LED/timer/status
// registers and presents read data one cycle after the request.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] MMIO_HI = 16'hBFAF,
  parameter int          LED_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_en,
  input  logic             memwrite,
  input  logic [3:0]       mem_wen,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [LED_W-1:0] led,
  output logic             timer_irq,
  output logic             err
);

  logic             isMmio, mmioHit, wenOk, wrOk, wrBad, rdReq;
  logic [1:0]       off;
  logic [31:0]      mmioVal, mmioQ, ramQ, count, cmp;
  logic [LED_W-1:0] ledReg;
  logic             stMatch, stErr, lastRam;
  logic             wrLed, wrCount, wrCmp, wrStatus;
  logic             unusedAddr;

  assign isMmio  = (addr[31:16] == MMIO_HI);
  assign mmioHit = isMmio && (addr[15:4] == 12'd0);
  assign off     = addr[3:2];
  assign wenOk   = legalWen(mem_wen);
  assign wrOk    = mem_en && memwrite && wenOk;
  assign wrBad   = mem_en && memwrite && !wenOk;
  assign rdReq   = mem_en && !memwrite;

  assign wrLed    = wrOk && mmioHit && (off == OFF_LED);
  assign wrCount  = wrOk && mmioHit && (off == OFF_COUNT);
  assign wrCmp    = wrOk && mmioHit && (off == OFF_CMP);
  assign wrStatus = wrOk && mmioHit && (off == OFF_STATUS) && mem_wen[0];

  // Byte offset within a word carries no meaning for this port.
  assign unusedAddr = ^addr[1:0];

  // RAM is gated off during reset so an in-flight write is dropped.
  dmem_ram #(.RAM_AW(RAM_AW)) uRam (
    .clk   (clk),
    .re    (rdReq && !isMmio && !rst),
    .we    (wrOk && !isMmio && !rst),
    .wen   (mem_wen),
    .idx   (addr[RAM_AW+1:2]),
    .wdata (wdata),
    .q     (ramQ)
  );

  // MMIO read mux; unmapped window offsets read as zero.
  always_comb begin
    mmioVal = '0;
    if (mmioHit)
      case (off)
        OFF_LED:    mmioVal = 32'(ledReg);
        OFF_COUNT:  mmioVal = count;
        OFF_CMP:    mmioVal = cmp;
        OFF_STATUS: begin
          mmioVal[ST_MATCH] = stMatch;
          mmioVal[ST_ERR]   = stErr;
        end
      endcase
  end

  // MMIO registers, timer, sticky status and read-source tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      ledReg  <= '0;
      count   <= '0;
      cmp     <= 32'hFFFF_FFFF;
      stMatch <= 1'b0;
      stErr   <= 1'b0;
      mmioQ   <= '0;
      lastRam <= 1'b0;
    end else begin
      if (wrLed) ledReg <= LED_W'(laneMerge(32'(ledReg), wdata, mem_wen));
      if (wrCmp) cmp <= laneMerge(cmp, wdata, mem_wen);
      count <= wrCount ? laneMerge(count, wdata, mem_wen) : count + 32'd1;
      // A match in the same cycle as a W1C clear wins.
      if (count == cmp)                   stMatch <= 1'b1;
      else if (wrStatus && wdata[ST_MATCH]) stMatch <= 1'b0;
      if (wrBad)                          stErr <= 1'b1;
      else if (wrStatus && wdata[ST_ERR]) stErr <= 1'b0;
      if (rdReq) begin
        lastRam <= !isMmio;
        if (isMmio) mmioQ <= mmioVal;
      end
    end
  end

  assign rdata     = lastRam ? ramQ : mmioQ;
  assign led       = ledReg;
  assign timer_irq = stMatch;
  assign err       = stErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized + directed bench for dmem_responder against a behavioural model.
module tb_dmem_responder;

  localparam int LED_W = 16;
  localparam logic [31:0] MB = 32'hBFAF_0000;

  logic             clk = 0;
  logic             rst = 1;
  logic             mem_en = 0, memwrite = 0;
  logic [3:0]       mem_wen = 0;
  logic [31:0]      addr = 0, wdata = 0;
  logic [31:0]      rdata;
  logic [LED_W-1:0] led;
  logic             timer_irq, err;

  dmem_responder #(.RAM_AW(10), .MMIO_HI(16'hBFAF), .LED_W(LED_W)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .memwrite(memwrite),
    .mem_wen(mem_wen), .addr(addr), .wdata(wdata), .rdata(rdata),
    .led(led), .timer_irq(timer_irq), .err(err)
  );

  always #5 clk = ~clk;

  int nChk = 0, nPass = 0;
  bit started = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]      mRam [1024];
  logic [LED_W-1:0] mLed;
  logic [31:0]      mCount, mCmp, mRd;
  bit               mMatch, mErr;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] w);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin : model
    bit hit, inWin;
    logic [31:0] nCount;
    if (rst) begin
      mLed = 0; mCount = 0; mCmp = 32'hFFFF_FFFF; mMatch = 0; mErr = 0; mRd = 0;
    end else begin
      hit    = (mCount == mCmp);
      nCount = mCount + 1;
      inWin  = (addr[31:16] == 16'hBFAF) && (addr[15:4] == 0);
      if (mem_en && !memwrite) begin
        if (addr[31:16] != 16'hBFAF) mRd = mRam[addr[11:2]];
        else if (!inWin) mRd = 0;
        else case (addr[3:2])
          0: mRd = {16'h0, mLed};
          1: mRd = mCount;
          2: mRd = mCmp;
          3: mRd = {30'h0, mErr, mMatch};
        endcase
      end else if (mem_en && memwrite) begin
        if (!(mem_wen inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF})) mErr = 1;
        else if (addr[31:16] != 16'hBFAF)
          mRam[addr[11:2]] = merge(mRam[addr[11:2]], wdata, mem_wen);
        else if (inWin) case (addr[3:2])
          0: mLed = 16'(merge({16'h0, mLed}, wdata, mem_wen));
          1: nCount = merge(mCount, wdata, mem_wen);
          2: mCmp = merge(mCmp, wdata, mem_wen);
          3: if (mem_wen[0]) begin
               if (wdata[0]) mMatch = 0;
               if (wdata[1]) mErr = 0;
             end
        endcase
      end
      if (hit) mMatch = 1;
      mCount = nCount;
    end
  end

  // Outputs checked against the model every cycle once out of reset.
  always @(negedge clk) begin
    if (started) begin
      check("rdata", rdata, mRd);
      check("led", 32'(led), 32'(mLed));
      check("timer_irq", 32'(timer_irq), 32'(mMatch));
      check("err", 32'(err), 32'(mErr));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit r, input bit en, input bit wr, input logic [3:0] w,
                      input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    rst = r; mem_en = en; memwrite = wr; mem_wen = w; addr = a; wdata = d;
  endtask
  task automatic wr32(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    step(0, 1, 1, w, a, d);
  endtask
  task automatic rd(input logic [31:0] a);
    step(0, 1, 0, $urandom, a, $urandom);
  endtask
  task automatic idle();
    step(0, 0, $urandom, $urandom, $urandom, $urandom);
  endtask

  initial begin
    int k;
    logic [3:0] legal [7];
    legal = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    started = 1;
    check("reset rdata", rdata, 0);
    check("reset led", 32'(led), 0);
    check("reset irq", 32'(timer_irq), 0);
    check("reset err", 32'(err), 0);
    for (int i = 0; i < 32; i++) wr32(i << 2, 0, 4'hF);

    // byte merge
    wr32(32'h10, 32'hDEADBEEF, 4'hF);
    wr32(32'h10, 32'h00AA0000, 4'h4);
    rd(32'h10); idle();
    check("byte merge", rdata, 32'hDEAA_BEEF);

    // halfword + illegal strobe + sticky err
    wr32(32'h20, 32'h12340000, 4'hC);
    rd(32'h20); idle();
    check("halfword", rdata, 32'h1234_0000);
    wr32(32'h20, 32'hFFFFFFFF, 4'h5); idle();
    check("err set", 32'(err), 1);
    rd(32'h20); idle();
    check("illegal no write", rdata, 32'h1234_0000);
    idle(); idle();
    check("err sticky", 32'(err), 1);
    wr32(MB | 32'hC, 32'h2, 4'hF); idle();
    check("err cleared", 32'(err), 0);

    // alias and unmapped window
    wr32(32'h8000_0010, 32'h55AA1234, 4'hF);
    rd(32'h10); idle();
    check("alias", rdata, 32'h55AA_1234);
    rd(32'hBFAF_0100); idle();
    check("unmapped", rdata, 0);

    // compare match
    wr32(MB | 32'h8, 5, 4'hF);
    wr32(MB | 32'h4, 0, 4'hF);
    k = 0;
    do begin idle(); k++; end while (!timer_irq && k < 20);
    check("irq latency", k, 7);
    wr32(MB | 32'hC, 1, 4'hF);
    wr32(MB | 32'h4, 0, 4'hF);
    check("irq w1c", 32'(timer_irq), 0);
    repeat (5) idle();
    wr32(MB | 32'hC, 1, 4'hF);
    idle();
    check("set beats clear", 32'(timer_irq), 1);

    // wrap and LED
    wr32(MB | 32'h4, 32'hFFFF_FFFE, 4'hF);
    idle(); idle();
    rd(MB | 32'h4); idle();
    check("count wrap", rdata, 0);
    wr32(MB, 32'h0000A5A5, 4'h3); idle();
    check("led", 32'(led), 32'h0000_A5A5);

    // reset during write
    wr32(32'h40, 32'h77, 4'hF);
    wr32(32'h1, 0, 4'h0);
    step(1, 1, 1, 4'hF, 32'h40, 32'h1);
    rd(MB | 32'h4);
    check("rst rdata", rdata, 0);
    check("rst led", 32'(led), 0);
    check("rst err", 32'(err), 0);
    rd(32'h40);
    check("rst count", rdata, 0);
    rd(MB | 32'hC);
    check("rst ram kept", rdata, 32'h77);
    idle();
    check("rst status", rdata, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a, d;
      logic [3:0] w;
      bit en, wrq;
      en  = ($urandom_range(0, 3) != 0);
      wrq = $urandom_range(0, 1);
      w   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal[$urandom_range(0, 6)];
      d   = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        a = {16'hBFAF, ($urandom_range(0, 9) == 0) ? 12'h010 : 12'h000,
             2'($urandom), 2'($urandom)};
        if (a[3:2] == 2 && $urandom_range(0, 1) == 1) begin d = mCount + $urandom_range(2, 30); w = 4'hF; end
      end else begin
        a = {($urandom_range(0, 1) == 1) ? 16'h8001 : 16'h0000, 6'h0,
             5'($urandom_range(0, 31)), 3'h0, 2'($urandom)};
      end
      step($urandom_range(0, 299) == 0, en, wrq, w, a, d);
    end
    idle(); idle();
    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the CPU core's data port. It serves the core's M-stage requests: address, write strobe, byte-lane enables and write data. It holds a word-addressed, byte-writable data RAM and a small MMIO register window with an LED register, a free-running timer with a compare match/IRQ, and a sticky error status. It sits between the core's data port and the board pins/interrupt line in the SoC top.

Parameters:
RAM_AW, 10, RAM word-address width (1024 x 32-bit words)
MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window
LED_W, 16, width of LED output register

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
mem_en  in  1  request valid this cycle
memwrite  in  1  1 = write request, 0 = read request
mem_wen  in  4  byte-lane write enables, lane i = wdata[8i+7:8i]
addr  in  32  byte address from the core ALU
wdata  in  32  write data, already lane-replicated by the core
rdata  out  32  read data, registered
led  out  LED_W  LED register contents
timer_irq  out  1  level interrupt = STATUS.match
err  out  1  = STATUS.err

Behaviour:
- Reset values: rdata=0, led=0, timer count=0, cmp=32'hFFFF_FFFF, STATUS=0, timer_irq=0, err=0. RAM contents are not reset.
- Decode: MMIO when addr[31:16]==MMIO_HI. Otherwise RAM, word index addr[RAM_AW+1:2]. Higher address bits are ignored (aliasing is defined behaviour).
- MMIO offsets, addr[3:2]: 0 LED (RW, low LED_W bits); 1 COUNT (RW); 2 CMP (RW); 3 STATUS (bit0 match, bit1 err, write-1-to-clear). addr[15:4]!=0 in the window reads 0 and ignores writes.
- Legal mem_wen when memwrite=1: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other value (including 0000): no state change, STATUS.err set (sticky).
- Write (mem_en & memwrite & legal mem_wen): RAM lanes with mem_wen[i]=1 update at the edge and the other lanes keep their value. MMIO registers are written with lane masking in the same way.
- Read latency is exactly 1 cycle: a request in cycle N returns data in rdata at edge N+1. rdata holds its value while mem_en=0 or on write cycles. An MMIO read returns the register value sampled in cycle N.
- Read-after-write to the same RAM word in consecutive cycles returns the new data (write-first RAM).
- Timer: COUNT increments by 1 every cycle and wraps 32'hFFFF_FFFF->0. A software write to COUNT takes priority over the increment that cycle.
- Match: when COUNT==CMP (pre-increment value), STATUS.match is set at the next edge. If the set and a W1C clear land in the same cycle, the set wins. timer_irq = STATUS.match, no extra delay.
- A write to CMP takes effect for comparison in the next cycle.
- Reset asserted during any request: the request is dropped, registers return to reset values, and any RAM write in that cycle is suppressed.
- mem_en=0: memwrite, mem_wen, addr and wdata are don't-care. No state change except the timer.

Decomposition:
- dmem_pkg: MMIO offset constants (OFF_LED, OFF_COUNT, OFF_CMP, OFF_STATUS), STATUS bit indices, legal-wen check function.
- Sub-module dmem_ram: single-port, 4-lane byte-write, write-first synchronous RAM parameterised by RAM_AW.
- Top: decode, MMIO registers, timer, rdata mux/register.

Test Plan:
- Write 32'hDEADBEEF to 0x0000_0010 with wen 1111, then write wdata 32'h00AA_0000 with wen 0100, then read 0x10 -> rdata 32'hDEAA_BEEF one cycle after the read request.
- Halfword write wen 1100, wdata 32'h1234_0000 to 0x20 (prior 0) -> read 0x20 gives 32'h1234_0000. Illegal wen 0101 to 0x20 -> word unchanged, err=1 and stays 1 until STATUS written with 32'h2.
- Write 0x8000_0010 then read 0x0000_0010 (RAM_AW=10) -> identical data (alias). Read 0xBFAF_0100 -> 0.
- Write CMP=5 and COUNT=0 in consecutive cycles -> timer_irq rises when COUNT reaches 5 (+1 edge). W1C STATUS=1 in the same cycle as a new match -> timer_irq stays 1.
- Write COUNT=32'hFFFF_FFFE -> after 2 cycles COUNT reads 0 (wrap). Write LED=16'hA5A5 with wen 0011 -> led=16'hA5A5.
- Assert rst for 1 cycle during a write of 32'h1 to 0x40 -> RAM word 0x40 keeps its old value. led, COUNT, STATUS and rdata read as reset values.
